// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between instruction fetch (IF)
//            and data load/store (D) traffic. It accepts one transaction at a
//            time, runs a req/ready handshake with memory, returns read data
//            or store completion to the owning side, and raises stall so the
//            PC and register file hold while traffic is outstanding.
//            When both sides request together, round-robin decides the
//            winner; D wins the first conflict after reset.
// Ports    : clk, rst                          - clock, synchronous active-high reset
//            if_req/if_addr                    - fetch request (held until if_gnt)
//            if_gnt/if_done/if_rdata           - fetch grant, completion, data
//            d_req/d_we/d_addr/d_wdata         - load/store request (held until d_gnt)
//            d_gnt/d_done/d_rdata              - data grant, completion, load data
//            mem_req/mem_we/mem_addr/mem_wdata - memory request side
//            mem_ready/mem_rdata               - memory response side
//            err                               - pulses with *_done on timeout abort
//            stall                             - combinational pipeline hold
// Options  : ARB_TIMEOUT_EN - when defined, an access that waits TIMEOUT
//            cycles for mem_ready is aborted with err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              stall
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_d;      // 1: most recent grant went to the D side
    logic       w_gnt_i;
    logic       w_gnt_d;
    logic       w_busy;
    logic       w_abort;
    logic       w_finish;

    assign w_busy   = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);
    // mem_ready is only meaningful while a request is outstanding.
    assign w_finish = w_busy && (mem_ready || w_abort);

`ifdef ARB_TIMEOUT_EN
    localparam int              c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_gnt_i || w_gnt_d) begin
            r_wait_cnt <= '0;
        end else if (w_busy && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // The counter holds the number of ready-less cycles already spent, so the
    // TIMEOUT-th waiting cycle is the one that aborts. A late mem_ready in
    // that same cycle still completes normally.
    assign w_abort = w_busy && !mem_ready && (r_wait_cnt == c_WAIT_LAST);
`else
    assign w_abort = 1'b0;
`endif

    // Next-state and grant decode. Grants are combinational so they land in
    // the same cycle the request is seen in IDLE; none are issued in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_i     = 1'b0;
        w_gnt_d     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!rst) begin
                    if (d_req && (!if_req || !r_last_d)) begin
                        w_gnt_d     = 1'b1;
                        w_state_nxt = c_BUSY_D;
                    end else if (if_req) begin
                        w_gnt_i     = 1'b1;
                        w_state_nxt = c_BUSY_I;
                    end
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (w_finish) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_last_d  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            if (w_gnt_d) begin
                r_last_d  <= 1'b1;
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (w_gnt_i) begin
                r_last_d  <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (w_finish) begin
                // Memory-side outputs return to their idle values once the
                // access is over, so a store's write strobe lasts exactly as
                // long as the handshake.
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                err       <= w_abort;
                if (r_state == c_BUSY_I) begin
                    if_done  <= 1'b1;
                    if_rdata <= w_abort ? '0 : mem_rdata;
                end else begin
                    d_done  <= 1'b1;
                    d_rdata <= (w_abort || mem_we) ? '0 : mem_rdata;
                end
            end
        end
    end

    assign if_gnt = w_gnt_i;
    assign d_gnt  = w_gnt_d;
    assign stall  = (if_req && !if_done) || (d_req && !d_done) || (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios
//            (load, store, round-robin conflict, reset mid-access, stray
//            mem_ready, long wait / timeout) followed by randomized traffic.
//            Expectations come from a transaction-level model: pending
//            requests per side, the last granted side, and the last data
//            returned to each side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;
    logic        stall;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic        p_i, p_d;            // side has an ungranted request
    logic        m_last_d;            // last grant went to D
    logic [31:0] m_if_rdata, m_d_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        adv();
        adv();
        rst = 1'b0;
        p_i = 1'b0; p_d = 1'b0; m_last_d = 1'b0;
        m_if_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic raise_i(input logic [31:0] a);
        if_addr = a; if_req = 1'b1; p_i = 1'b1;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; p_d = 1'b1;
    endtask

    // Entered at the sampling point of a cycle in which the arbiter is idle
    // and at least one side is pending; leaves at the sampling point of the
    // completion cycle. delay = ready-less cycles before mem_ready.
    task automatic serve(input bit rearm, input int delay);
        logic        g_d;
        logic        e_we;
        logic [31:0] e_addr, e_wdata, rd, e_stall;
        g_d = p_d && (!p_i || !m_last_d);
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, g_d});
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, !g_d});
        chk("stall_grant", {31'd0, stall}, 32'd1);
        m_last_d = g_d;
        e_we    = g_d ? d_we : 1'b0;
        e_addr  = g_d ? d_addr : if_addr;
        e_wdata = g_d ? d_wdata : 32'd0;
        rd = '0;
        adv();
        if (!rearm) begin
            if (g_d) begin p_d = 1'b0; d_req = 1'b0; end
            else     begin p_i = 1'b0; if_req = 1'b0; end
        end
        for (int k = 0; k <= delay; k++) begin
            mem_rdata = $urandom;
            mem_ready = (k == delay);
            if (k == delay) rd = mem_rdata;
            @(negedge clk);
            chk("mem_req_busy", {31'd0, mem_req}, 32'd1);
            chk("mem_we_busy", {31'd0, mem_we}, {31'd0, e_we});
            chk("mem_addr_busy", mem_addr, e_addr);
            chk("mem_wdata_busy", mem_wdata, e_wdata);
            chk("no_gnt_busy", {30'd0, if_gnt, d_gnt}, 32'd0);
            chk("no_done_busy", {30'd0, if_done, d_done}, 32'd0);
            chk("stall_busy", {31'd0, stall}, 32'd1);
            chk("if_rdata_hold", if_rdata, m_if_rdata);
            chk("d_rdata_hold", d_rdata, m_d_rdata);
            adv();
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (g_d) m_d_rdata = e_we ? 32'd0 : rd;
        else     m_if_rdata = rd;
        e_stall = {31'd0, (if_req && g_d) || (d_req && !g_d)};
        @(negedge clk);
        chk("d_done", {31'd0, d_done}, {31'd0, g_d});
        chk("if_done", {31'd0, if_done}, {31'd0, !g_d});
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk("err_done", {31'd0, err}, 32'd0);
        chk("stall_done", {31'd0, stall}, e_stall);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
        chk({tag, "_done"}, {30'd0, if_done, d_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, m_if_rdata);
        chk({tag, "_d_rdata"}, d_rdata, m_d_rdata);
    endtask

    initial begin
        if_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Load with two request cycles
        adv();
        raise_d(1'b0, 32'h40, 32'h0);
        @(negedge clk);
        begin
            // force the returned word for this directed case
            logic [31:0] tmp;
            tmp = 32'hDEADBEEF;
            chk("load_gnt", {31'd0, d_gnt}, 32'd1);
            m_last_d = 1'b1; p_d = 1'b0;
            adv(); d_req = 1'b0;
            @(negedge clk); chk("load_req1", {31'd0, mem_req}, 32'd1);
            chk("load_addr", mem_addr, 32'h40);
            adv(); mem_ready = 1'b1; mem_rdata = tmp;
            @(negedge clk); chk("load_req2", {31'd0, mem_req}, 32'd1);
            chk("load_stall2", {31'd0, stall}, 32'd1);
            adv(); mem_ready = 1'b0; mem_rdata = 32'h0;
            m_d_rdata = tmp;
            @(negedge clk);
            chk("load_done", {31'd0, d_done}, 32'd1);
            chk("load_rdata", d_rdata, tmp);
            chk("load_req3", {31'd0, mem_req}, 32'd0);
        end

        // Store, immediate ready
        adv();
        raise_d(1'b1, 32'h44, 32'h12345678);
        @(negedge clk);
        serve(1'b0, 0);

        // Stray mem_ready while idle
        adv();
        mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk_quiet("stray0");
        adv();
        mem_ready = 1'b0;
        @(negedge clk);
        chk_quiet("stray1");

        // Conflict from reset, both held: D, IF, D, IF
        do_reset();
        raise_i(32'h1000);
        raise_d(1'b0, 32'h2000, 32'h0);
        @(negedge clk);
        serve(1'b1, 0);
        serve(1'b1, 0);
        serve(1'b0, 0);
        serve(1'b0, 0);

        // Reset during a fetch access
        adv();
        raise_i(32'h100);
        @(negedge clk);
        chk("rstmid_gnt", {31'd0, if_gnt}, 32'd1);
        adv(); if_req = 1'b0; p_i = 1'b0;
        @(negedge clk); chk("rstmid_busy", {31'd0, mem_req}, 32'd1);
        adv(); rst = 1'b1;
        @(negedge clk); chk("rstmid_busy2", {31'd0, mem_req}, 32'd1);
        adv(); rst = 1'b0;
        m_last_d = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
        @(negedge clk);
        chk_quiet("rstmid_after");
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        adv();
        @(negedge clk);
        chk_quiet("rstmid_after2");
        adv();
        raise_i(32'h200);
        @(negedge clk);
        serve(1'b0, 1);

        // Memory that never answers
        adv();
        raise_d(1'b0, 32'h80, 32'h0);
        @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        chk("to_gnt", {31'd0, d_gnt}, 32'd1);
        m_last_d = 1'b1;
        adv(); d_req = 1'b0; p_d = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("to_wait_req", {31'd0, mem_req}, 32'd1);
            chk("to_wait_done", {30'd0, d_done, err}, 32'd0);
            adv();
        end
        m_d_rdata = '0;
        @(negedge clk);
        chk("to_done_err", {30'd0, d_done, err}, 32'd3);
        chk("to_rdata", d_rdata, 32'd0);
        chk("to_mem_req", {31'd0, mem_req}, 32'd0);
`else
        serve(1'b0, 30);
`endif

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int sel;
            adv();
            sel = int'($urandom_range(1, 3));
            if (sel[0]) raise_i($urandom);
            if (sel[1]) raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            @(negedge clk);
            while (p_i || p_d) serve(1'b0, int'($urandom_range(0, 3)));
        end

        adv();
        @(negedge clk);
        chk_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
